// File: rtl/camera64x64_reader_if.sv
// Pixel-stream and camera-link signals of the 64x64 camera reader.
// master = reader side, slave = camera/consumer side.
interface camera64x64_reader_if #(
  parameter int PIX_W = 8
);
  logic             start;
  logic             sdata;
  logic             sclk;
  logic             busy;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic [5:0]       pix_x;
  logic [5:0]       pix_y;
  logic             line_end;
  logic             frame_end;
  logic [15:0]      frame_sum;

  modport master (
    input  start, sdata,
    output sclk, busy, pix_data, pix_valid, pix_x, pix_y, line_end, frame_end, frame_sum
  );

  modport slave (
    output start, sdata,
    input  sclk, busy, pix_data, pix_valid, pix_x, pix_y, line_end, frame_end, frame_sum
  );
endinterface

// File: rtl/camera64x64_reader.sv
// Burst-mode SCLK generator and SDATA deserialiser for the 64x64 dummy camera.
// Optional frame checksum on FRAME_SUM when CAMERA64X64_READER_SUM_EN is defined.
module camera64x64_reader #(
  parameter int PIX_W         = 8,
  parameter int PIX_PER_BURST = 3,
  parameter int GAP_CYCLES    = 108000,
  parameter int FRAME_PIX     = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  camera64x64_reader_if.master  bus
);
  localparam int PCW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int BCW = (PIX_PER_BURST > 1) ? $clog2(PIX_PER_BURST) : 1;
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam int KCW = $clog2(PIX_W + 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  state_t           state_r;
  logic             sclk_r;
  logic             busy_r;
  logic [PIX_W-1:0] shreg_r;
  logic [KCW-1:0]   bit_cnt_r;
  logic [PCW-1:0]   pix_cnt_r;
  logic [BCW-1:0]   burst_r;
  logic [GCW-1:0]   gap_cnt_r;
  logic [5:0]       col_r;
  logic [5:0]       row_r;
  logic [PIX_W-1:0] pix_data_r;
  logic             pix_valid_r;
  logic [5:0]       pix_x_r;
  logic [5:0]       pix_y_r;
  logic             line_end_r;
  logic             frame_end_r;
  logic             last_frame_s;
  logic             last_burst_s;
`ifdef CAMERA64X64_READER_SUM_EN
  logic [15:0]      sum_r;
`endif

  assign last_frame_s = (pix_cnt_r == PCW'(FRAME_PIX - 1));
  assign last_burst_s = (burst_r == BCW'(PIX_PER_BURST - 1));

  // Frame FSM: SCLK bursts, bit sampling, pixel emission and coordinate tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sclk_r      <= 1'b0;
      busy_r      <= 1'b0;
      shreg_r     <= '0;
      bit_cnt_r   <= '0;
      pix_cnt_r   <= '0;
      burst_r     <= '0;
      gap_cnt_r   <= '0;
      col_r       <= 6'd0;
      row_r       <= 6'd0;
      pix_data_r  <= '0;
      pix_valid_r <= 1'b0;
      pix_x_r     <= 6'd0;
      pix_y_r     <= 6'd0;
      line_end_r  <= 1'b0;
      frame_end_r <= 1'b0;
`ifdef CAMERA64X64_READER_SUM_EN
      sum_r       <= 16'd0;
`endif
    end else begin
      pix_valid_r <= 1'b0;
      line_end_r  <= 1'b0;
      frame_end_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // BUSY is still high on the FRAME_END cycle, so a START there is dropped.
          if (bus.start && !busy_r) begin
            state_r   <= LEAD;
            busy_r    <= 1'b1;
            sclk_r    <= 1'b1;
            bit_cnt_r <= '0;
            pix_cnt_r <= '0;
            burst_r   <= '0;
            col_r     <= 6'd0;
            row_r     <= 6'd0;
            pix_x_r   <= 6'd0;
            pix_y_r   <= 6'd0;
`ifdef CAMERA64X64_READER_SUM_EN
            sum_r     <= 16'd0;
`endif
          end else begin
            busy_r <= 1'b0;
            sclk_r <= 1'b0;
          end
        end
        LEAD: begin
          if (sclk_r) begin
            sclk_r <= 1'b0;
          end else begin
            sclk_r  <= 1'b1;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_r) begin
            shreg_r   <= {shreg_r[PIX_W-2:0], bus.sdata};
            bit_cnt_r <= bit_cnt_r + 1'b1;
            sclk_r    <= 1'b0;
          end else if (bit_cnt_r == KCW'(PIX_W)) begin
            pix_data_r  <= shreg_r;
            pix_valid_r <= 1'b1;
            pix_x_r     <= col_r;
            pix_y_r     <= row_r;
            line_end_r  <= (col_r == 6'd63);
            frame_end_r <= last_frame_s;
            col_r       <= col_r + 6'd1;
            row_r       <= (col_r == 6'd63) ? row_r + 6'd1 : row_r;
            pix_cnt_r   <= pix_cnt_r + 1'b1;
            bit_cnt_r   <= '0;
`ifdef CAMERA64X64_READER_SUM_EN
            sum_r       <= sum_r + 16'(shreg_r);
`endif
            if (last_frame_s) begin
              state_r <= IDLE;
            end else if (last_burst_s) begin
              state_r   <= GAP;
              gap_cnt_r <= '0;
              burst_r   <= '0;
            end else begin
              burst_r <= burst_r + 1'b1;
              sclk_r  <= 1'b1;
            end
          end else begin
            sclk_r <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_r == GCW'(GAP_CYCLES - 1)) begin
            state_r <= LEAD;
            sclk_r  <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          sclk_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sclk      = sclk_r;
  assign bus.busy      = busy_r;
  assign bus.pix_data  = pix_data_r;
  assign bus.pix_valid = pix_valid_r;
  assign bus.pix_x     = pix_x_r;
  assign bus.pix_y     = pix_y_r;
  assign bus.line_end  = line_end_r;
  assign bus.frame_end = frame_end_r;
`ifdef CAMERA64X64_READER_SUM_EN
  assign bus.frame_sum = sum_r;
`else
  assign bus.frame_sum = 16'd0;
`endif
endmodule

// File: tb/tb_camera64x64_reader.sv
// Directed bench for camera64x64_reader: camera model on SDATA, pixel capture,
// table of expected full-frame pixels plus hand sequences for reset, gap and restart.
module tb_camera64x64_reader;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  camera64x64_reader_if #(.PIX_W(8)) bus();

  camera64x64_reader #(
    .PIX_W(8), .PIX_PER_BURST(3), .GAP_CYCLES(GAP), .FRAME_PIX(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic [5:0] x;
    logic [5:0] y;
    logic       le;
    logic       fe;
  } vec_t;

  vec_t tbl [9];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int bit_idx = 0;
  int mode = 0;
  int low_run = 100;
  int fall_cyc = 0;
  int gap_meas = 0;
  int cur_rises = 0;
  int leads = 0;
  logic prev_sclk = 1'b0;

  logic [7:0] cap_d [4096];
  logic [5:0] cap_x [4096];
  logic [5:0] cap_y [4096];
  logic       cap_le [4096];
  logic       cap_fe [4096];
  int cap_n = 0;
  int le_cnt = 0;
  int fe_cnt = 0;
  int fe_rises = 0;
  logic [15:0] fe_sum = 16'd0;
  logic sum_nonzero = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_model(input int n);
    logic [7:0] v;
    v = 8'(n);
    if (mode == 0) begin
      case (n)
        0:       v = 8'hA5;
        1:       v = 8'h3C;
        2:       v = 8'hFF;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  // One clock: camera model drives SDATA during the SCLK high phase, monitor captures outputs.
  task automatic step();
    logic [7:0] p;
    @(negedge clk);
    cyc++;
    if (bus.sclk) begin
      if (!prev_sclk) begin
        if (low_run >= 2) begin
          cur_rises = 1;
          leads++;
          gap_meas = cyc - fall_cyc;
          bus.sdata = 1'b1;
        end else begin
          cur_rises++;
          p = pix_model(bit_idx / 8);
          bus.sdata = p[7 - (bit_idx % 8)];
          bit_idx++;
        end
      end
      low_run = 0;
    end else begin
      if (prev_sclk) fall_cyc = cyc;
      low_run++;
    end
    prev_sclk = bus.sclk;
    if (bus.pix_valid) begin
      if (cap_n < 4096) begin
        cap_d[cap_n]  = bus.pix_data;
        cap_x[cap_n]  = bus.pix_x;
        cap_y[cap_n]  = bus.pix_y;
        cap_le[cap_n] = bus.line_end;
        cap_fe[cap_n] = bus.frame_end;
      end
      cap_n++;
      if (bus.line_end) le_cnt++;
      if (bus.frame_end) begin
        fe_cnt++;
        fe_rises = cur_rises;
        fe_sum = bus.frame_sum;
      end
    end
    if (bus.frame_sum != 16'd0) sum_nonzero = 1'b1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    bit_idx = 0;
    cap_n = 0;
    le_cnt = 0;
    fe_cnt = 0;
    leads = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_pix(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cap_n < n && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(cap_n >= n), 32'd1);
  endtask

  initial begin
    logic [7:0] b1 [3];
    int k;
    int hi;
    b1 = '{8'hA5, 8'h3C, 8'hFF};
    tbl[0] = '{0,    8'h00, 6'd0,  6'd0,  1'b0, 1'b0};
    tbl[1] = '{63,   8'h3F, 6'd63, 6'd0,  1'b1, 1'b0};
    tbl[2] = '{64,   8'h40, 6'd0,  6'd1,  1'b0, 1'b0};
    tbl[3] = '{255,  8'hFF, 6'd63, 6'd3,  1'b1, 1'b0};
    tbl[4] = '{256,  8'h00, 6'd0,  6'd4,  1'b0, 1'b0};
    tbl[5] = '{1000, 8'hE8, 6'd40, 6'd15, 1'b0, 1'b0};
    tbl[6] = '{2047, 8'hFF, 6'd63, 6'd31, 1'b1, 1'b0};
    tbl[7] = '{4094, 8'hFE, 6'd62, 6'd63, 1'b0, 1'b0};
    tbl[8] = '{4095, 8'hFF, 6'd63, 6'd63, 1'b1, 1'b1};

    bus.start = 1'b0;
    bus.sdata = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_sclk", 32'(bus.sclk), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_outs", {bus.pix_valid, bus.line_end, bus.frame_end, bus.pix_x, bus.pix_y, bus.pix_data}, 32'd0);
    check("rst_sum", 32'(bus.frame_sum), 32'd0);

    // Single burst with the A5/3C/FF pattern
    mode = 0;
    do_start();
    check("start_busy", 32'(bus.busy), 32'd1);
    run_pix(3, 200, "burst1_done");
    check("burst1_rises", 32'(cur_rises), 32'd25);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("burst1_data%0d", i), 32'(cap_d[i]), 32'(b1[i]));
      check($sformatf("burst1_x%0d", i), 32'(cap_x[i]), 32'(i));
    end

    // Gap between burst 1 and burst 2
    k = 0;
    while (leads < 2 && k < 500) begin
      step();
      k++;
    end
    check("gap_seen", 32'(leads), 32'd2);
    check("gap_len", 32'(gap_meas), 32'(GAP + 1));
    check("gap_no_pix", 32'(cap_n), 32'd3);

    // Reset asserted mid-SHIFT
    run_pix(4, 200, "burst2_pix");
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_sclk", 32'(bus.sclk), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_valid", 32'(bus.pix_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    hi = 0;
    repeat (20) begin
      step();
      if (bus.sclk || bus.busy) hi++;
    end
    check("idle_quiet", 32'(hi), 32'd0);

    // Full frame, pixel = index mod 256, with an ignored START mid-frame
    mode = 1;
    do_start();
    run_pix(100, 10000, "frame_100");
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_ignore", 32'(bus.busy), 32'd1);
    k = 0;
    while (fe_cnt < 1 && k < 80000) begin
      step();
      k++;
    end
    check("frame_done", 32'(fe_cnt >= 1), 32'd1);
    check("busy_at_fe", 32'(bus.busy), 32'd1);
    check("pix_count", 32'(cap_n), 32'd4096);
    check("line_end_count", 32'(le_cnt), 32'd64);
    check("frame_end_count", 32'(fe_cnt), 32'd1);
    check("final_rises", 32'(fe_rises), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tbl%0d_data", tbl[i].idx), 32'(cap_d[tbl[i].idx]), 32'(tbl[i].d));
      check($sformatf("tbl%0d_x", tbl[i].idx), 32'(cap_x[tbl[i].idx]), 32'(tbl[i].x));
      check($sformatf("tbl%0d_y", tbl[i].idx), 32'(cap_y[tbl[i].idx]), 32'(tbl[i].y));
      check($sformatf("tbl%0d_le", tbl[i].idx), 32'(cap_le[tbl[i].idx]), 32'(tbl[i].le));
      check($sformatf("tbl%0d_fe", tbl[i].idx), 32'(cap_fe[tbl[i].idx]), 32'(tbl[i].fe));
    end
`ifdef CAMERA64X64_READER_SUM_EN
    check("frame_sum", 32'(fe_sum), 32'h0000F800);
`else
    check("frame_sum_zero", 32'(sum_nonzero), 32'd0);
`endif

    // BUSY falls the cycle after FRAME_END; START there starts a new frame
    step();
    check("busy_fall", 32'(bus.busy), 32'd0);
    do_start();
    check("restart_busy", 32'(bus.busy), 32'd1);
    run_pix(1, 200, "restart_pix");
    check("restart_x", 32'(cap_x[0]), 32'd0);
    check("restart_y", 32'(cap_y[0]), 32'd0);
    check("restart_data", 32'(cap_d[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/camera64x64_reader.md
Name: camera64x64_reader

Overview:
Host-side reader for the 64x64 dummy camera. It generates the burst-mode serial clock SCLK from CLK and deserialises the camera's serial data line, SDATA, into 8-bit pixels. It also tracks pixel column, row and frame boundaries. The block sits directly upstream of the camera, which it feeds with SCLK, and is also the consumer of the camera's pixel stream.

Parameters:
PIX_W, 8, bits per pixel, shifted MSB first.
PIX_PER_BURST, 3, pixels transferred per SCLK burst.
GAP_CYCLES, 108000, CLK cycles of SCLK-low idle between bursts (9 ms at 12 MHz).
FRAME_PIX, 4096, pixels per frame (64x64).

Ports:
CLK  in  1  system clock, 12 MHz
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; begins a frame read when idle
SDATA  in  1  serial pixel data from the camera; changes after SCLK falling edge
SCLK  out  1  burst serial clock, CLK/2, idle low
BUSY  out  1  high from accepted START until FRAME_END cycle inclusive
PIX_DATA  out  PIX_W  last assembled pixel
PIX_VALID  out  1  one-cycle strobe, PIX_DATA valid
PIX_X  out  6  column of the current PIX_DATA
PIX_Y  out  6  row of the current PIX_DATA
LINE_END  out  1  with PIX_VALID when PIX_X==63
FRAME_END  out  1  with PIX_VALID on pixel FRAME_PIX-1
FRAME_SUM  out  16  frame checksum (optional feature only; otherwise tied 0)

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset applies on the next CLK edge regardless of state, including mid-burst; SCLK drops low the same edge.
- FSM states: IDLE, LEAD, SHIFT, GAP.
- IDLE:
  - START=1 -> LEAD next cycle, BUSY=1; pixel counter, bit counter, X and Y are cleared.
  - START while BUSY is ignored.
- SCLK generation: in LEAD and SHIFT, SCLK toggles every CLK cycle, starting high on the first cycle of the state. Each pulse is one CLK high followed by one CLK low.
- LEAD: exactly one SCLK pulse. Data on SDATA during this pulse is discarded. Then -> SHIFT.
- SHIFT:
  - SDATA is sampled on the CLK edge that drives SCLK high->low (end of the high phase) and shifted in MSB first.
  - After PIX_W samples, the pixel is complete. On the following CLK edge: PIX_DATA is updated, PIX_VALID pulses for 1 cycle, and PIX_X/PIX_Y hold that pixel's coordinates.
  - Latency: PIX_VALID is asserted 1 CLK after the final bit sample.
- Burst length: min(PIX_PER_BURST, remaining pixels) pixels. The default frame has 1365 full bursts of 25 pulses, then a final burst of 1 lead + 8 pulses, because 4096 mod 3 = 1.
- Burst end: SCLK is low. If pixels remain -> GAP. If the frame is complete -> IDLE, and BUSY deasserts the cycle after FRAME_END.
- GAP: count GAP_CYCLES with SCLK low, then -> LEAD.
- Coordinates:
  - PIX_X increments mod 64 on each pixel.
  - PIX_Y increments when PIX_X wraps 63->0.
  - LINE_END and FRAME_END coincide with PIX_VALID. On the last pixel both are 1, with X=63 and Y=63.
- Timing: START may arrive the cycle after FRAME_END and is accepted, since BUSY is already 0 by then.

Optional Feature:
CAMERA64X64_READER_SUM_EN
- Defined:
  - FRAME_SUM is a 16-bit wrap-around sum of all PIX_DATA values in the frame.
  - It is updated with each PIX_VALID, cleared on an accepted START, and final on the FRAME_END cycle.
  - It holds its value until the next START.
- Undefined: FRAME_SUM is constant 0 and no adder is synthesised.

Test Plan:
1. Reset: RST=1 for 3 cycles during SHIFT -> next cycle SCLK=0, BUSY=0, PIX_VALID=0, FSM in IDLE; SCLK stays 0 with no START.
2. Single burst: START; the model drives SDATA with pixels 0xA5, 0x3C, 0xFF -> first SCLK burst has exactly 25 rising edges; PIX_VALID fires 3 times with those values and X = 0, 1, 2.
3. Gap timing: measure from the last falling edge of burst 1 to the first rising edge of burst 2 -> exactly GAP_CYCLES+1 CLK (108001 at defaults; run with GAP_CYCLES=20 for speed -> 21).
4. Full frame (GAP_CYCLES=4): pixel value = index mod 256 ->
   - 4096 PIX_VALID strobes;
   - LINE_END 64 times;
   - FRAME_END once, at X=63, Y=63, data 0xFF;
   - final burst has 9 rising edges;
   - BUSY falls the cycle after FRAME_END.
5. START while BUSY pulsed mid-frame -> ignored; counters continue. START the cycle after FRAME_END -> new frame begins with X=0, Y=0.
6. SUM_EN build, full frame with index mod 256 -> FRAME_SUM = 16*32640 mod 65536 = 0xF800 at FRAME_END. Non-SUM build -> FRAME_SUM=0 throughout.
